dna_pattern_scanner: RTL and testbench
======================================

DNA_PATTERN_SCANNER -- requirements
Module: dna_pattern_scanner

Interface
REQ-001 Parameter BASES, 8, number of 4-bit bases in bigSeq; minimum 2.
REQ-002 Parameter PAT_BASES, 2, number of 4-bit bases in smallSeq; minimum 1, at most BASES.
REQ-003 Parameter LOC_W, clog2(BASES), width of base indices.
REQ-004 Parameter MM_W, 2, width of the mismatch limit and mismatch count.
REQ-005 Port CLK, in, 1, the single clock; all logic on its rising edge.
REQ-006 Port RST, in, 1, reset; synchronous and active-high.
REQ-007 Port START, in, 1, requests a scan; ignored unless the state is IDLE or COMPLETE.
REQ-008 Port bigSeq, in, 4*BASES, text; base i occupies bits [4i+3:4i].
REQ-009 Port smallSeq, in, 4*PAT_BASES, pattern; base j occupies bits [4j+3:4j].
REQ-010 Port startIndex, in, LOC_W, highest text base index to scan from.
REQ-011 Port mismatchLimit, in, MM_W, maximum mismatching bases tolerated per hit.
REQ-012 Port findAll, in, 1, 0 = stop at first hit; 1 = report every hit.
REQ-013 Port outReady, in, 1, consumer ready for the hit stream.
REQ-014 Port matchValid, out, 1, hit stream valid.
REQ-015 Port matchLoc / matchMm, out, LOC_W / MM_W, hit position and its mismatch count.
REQ-016 Ports found, location, matchCount, DONE, currState; out; 1, LOC_W, LOC_W+1, 1, 5; meanings: any hit, first-hit position, accepted hits, scan finished, one-hot state.

Function
REQ-017 Two bases match when (a & b) != 0 or a == b; 4'b1111 acts as a wildcard.
REQ-018 Alignment p compares text base p-k with pattern base PAT_BASES-1-k for k = 0..PAT_BASES-1.
REQ-019 Alignments run from p = startIndex down to PAT_BASES-1 in steps of one base.
REQ-020 States are IDLE, LOAD, COMPARE, EMIT, COMPLETE, one-hot in that bit order; currState mirrors the state.
REQ-021 IDLE/COMPLETE with START=1: go to LOAD and clear found, location, matchCount and DONE.
REQ-022 LOAD lasts 1 cycle and captures every input; no input is sampled afterwards.
REQ-023 LOAD exit: if startIndex < PAT_BASES-1 or startIndex >= BASES, go to COMPLETE; otherwise go to COMPARE with p = startIndex, k = 0, mm = 0.
REQ-024 COMPARE evaluates one base per cycle; on a mismatch, mm increments.
REQ-025 COMPARE abort: when mm would exceed mismatchLimit, the current alignment is abandoned that cycle.
REQ-026 After an abort, go to COMPLETE if p == PAT_BASES-1; otherwise set p = p-1, k = 0, mm = 0.
REQ-027 COMPARE hit: when k == PAT_BASES-1 without an abort, go to EMIT with matchLoc = p and matchMm = final mm.
REQ-028 On a hit, found is set; location is loaded only if this is the first hit of the scan.
REQ-029 EMIT asserts matchValid; matchLoc and matchMm stay stable until matchValid && outReady.
REQ-030 On the EMIT handshake, matchCount increments.
REQ-031 EMIT exit: go to COMPLETE if findAll == 0 or p == PAT_BASES-1; otherwise continue COMPARE at p-1.
REQ-032 COMPLETE holds DONE = 1 until START restarts the scan; matchValid is 0 outside EMIT.
REQ-033 matchCount saturates at all-ones.
REQ-034 START while in LOAD, COMPARE or EMIT has no effect.

Reset
REQ-035 With RST=1 at a clock edge, the state becomes IDLE.
REQ-036 The same edge clears matchValid, matchLoc, matchMm, found, location, matchCount and DONE to 0, and clears p, k and mm.
REQ-037 Reset overrides any state, including mid-COMPARE and EMIT with a pending handshake; a pending hit is discarded and not counted.

Structure
REQ-038 Package dna_search_pkg holds the base encodings (A=4'b0001, C=4'b0010, G=4'b0100, T=4'b1000, N=4'b1111), the state encodings and the base-match function.
REQ-039 Sub-module dna_base_match implements REQ-017 as one combinational 4-bit comparator; the index counters, mm counter and FSM stay in dna_pattern_scanner.

Verification (BASES=8, PAT_BASES=2; text 32'h1248_1248 = bases 7..0 A,C,G,T,A,C,G,T; startIndex=7)
REQ-040 smallSeq=8'h24 (C,G), limit 0, findAll 0 -> one matchValid with matchLoc=6, matchMm=0; found=1, location=6, matchCount=1, DONE.
REQ-041 Same with findAll 1, outReady=1 -> hits 6 then 2; matchCount=2; location=6.
REQ-042 Same as REQ-041 with outReady low for 5 cycles at the first hit -> matchValid, matchLoc=6 and matchMm stay stable; matchCount stays 0 until the handshake.
REQ-043 smallSeq=8'h88 (T,T), limit 1, findAll 1 -> hits 5,4,1 in that order, each matchMm=1, matchCount=3.
REQ-044 smallSeq=8'hFF, limit 0, findAll 1 -> hits 7..1, matchCount=7; with startIndex=0 -> DONE 2 cycles after START, found=0, matchCount=0.
REQ-045 RST=1 during COMPARE of the REQ-041 run -> next edge: IDLE, all outputs 0; a following START rescans correctly.

Source files
------------

// File: rtl/dna_search_pkg.sv
// Base encodings, one-hot scanner states and the base-match rule
// shared by the DNA pattern scanner.
package dna_search_pkg;

  localparam logic [3:0] BASE_A = 4'b0001;
  localparam logic [3:0] BASE_C = 4'b0010;
  localparam logic [3:0] BASE_G = 4'b0100;
  localparam logic [3:0] BASE_T = 4'b1000;
  localparam logic [3:0] BASE_N = 4'b1111;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_LOAD     = 5'b00010,
    ST_COMPARE  = 5'b00100,
    ST_EMIT     = 5'b01000,
    ST_COMPLETE = 5'b10000
  } state_t;

  // Overlapping bits cover ambiguity codes; N matches everything.
  function automatic logic base_match(
    input logic [3:0] a,
    input logic [3:0] b
  );
    return (|(a & b)) || (a == b);
  endfunction

endpackage

// File: rtl/dna_base_match.sv
// Combinational comparator for one pair of 4-bit bases.
module dna_base_match
  import dna_search_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       match
);

  assign match = base_match(a, b);

endmodule

// File: rtl/dna_pattern_scanner.sv
// Approximate pattern scanner: one base compared per cycle, hits
// streamed out over a valid/ready handshake.
module dna_pattern_scanner
  import dna_search_pkg::*;
#(
  parameter int BASES     = 8,
  parameter int PAT_BASES = 2,
  parameter int LOC_W     = $clog2(BASES),
  parameter int MM_W      = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [4*BASES-1:0]     bigSeq,
  input  logic [4*PAT_BASES-1:0] smallSeq,
  input  logic [LOC_W-1:0]       startIndex,
  input  logic [MM_W-1:0]        mismatchLimit,
  input  logic                   findAll,
  input  logic                   outReady,
  output logic                   matchValid,
  output logic [LOC_W-1:0]       matchLoc,
  output logic [MM_W-1:0]        matchMm,
  output logic                   found,
  output logic [LOC_W-1:0]       location,
  output logic [LOC_W:0]         matchCount,
  output logic                   DONE,
  output logic [4:0]             currState
);

  localparam logic [LOC_W-1:0] P_LAST  = LOC_W'(PAT_BASES - 1);
  localparam logic [LOC_W:0]   CNT_MAX = '1;

  state_t                 state;
  logic [4*BASES-1:0]     text;
  logic [4*PAT_BASES-1:0] pat;
  logic [MM_W-1:0]        limit;
  logic                   all;
  logic [LOC_W-1:0]       p;
  logic [LOC_W-1:0]       k;
  logic [MM_W-1:0]        mm;

  logic [LOC_W-1:0] t_idx;
  logic [LOC_W-1:0] s_idx;
  logic [3:0]       t_base;
  logic [3:0]       s_base;
  logic             base_ok;
  logic [MM_W:0]    mm_next;
  logic             abort;
  logic             last_k;
  logic             last_p;
  logic             bad_start;

  assign t_idx  = p - k;
  assign s_idx  = P_LAST - k;
  assign t_base = text[{t_idx, 2'b00} +: 4];
  assign s_base = pat[{s_idx, 2'b00} +: 4];

  dna_base_match u_match (
    .a     (t_base),
    .b     (s_base),
    .match (base_ok)
  );

  // One extra bit so a mismatch at mm == all-ones still aborts.
  assign mm_next = {1'b0, mm} + (MM_W + 1)'(!base_ok);
  assign abort   = mm_next > {1'b0, limit};
  assign last_k  = k == P_LAST;
  assign last_p  = p == P_LAST;

  assign bad_start = (startIndex < P_LAST) ||
                     (32'(startIndex) >= 32'(BASES));

  assign currState = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      matchValid <= 1'b0;
      matchLoc   <= '0;
      matchMm    <= '0;
      found      <= 1'b0;
      location   <= '0;
      matchCount <= '0;
      DONE       <= 1'b0;
      text       <= '0;
      pat        <= '0;
      limit      <= '0;
      all        <= 1'b0;
      p          <= '0;
      k          <= '0;
      mm         <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_COMPLETE: begin
          if (START) begin
            state      <= ST_LOAD;
            found      <= 1'b0;
            location   <= '0;
            matchCount <= '0;
            DONE       <= 1'b0;
          end
        end
        ST_LOAD: begin
          text  <= bigSeq;
          pat   <= smallSeq;
          limit <= mismatchLimit;
          all   <= findAll;
          p     <= startIndex;
          k     <= '0;
          mm    <= '0;
          if (bad_start) begin
            state <= ST_COMPLETE;
            DONE  <= 1'b1;
          end else begin
            state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (abort) begin
            k  <= '0;
            mm <= '0;
            if (last_p) begin
              state <= ST_COMPLETE;
              DONE  <= 1'b1;
            end else begin
              p <= p - 1'b1;
            end
          end else if (last_k) begin
            state      <= ST_EMIT;
            matchValid <= 1'b1;
            matchLoc   <= p;
            matchMm    <= mm_next[MM_W-1:0];
            found      <= 1'b1;
            if (!found) location <= p;
          end else begin
            k  <= k + 1'b1;
            mm <= mm_next[MM_W-1:0];
          end
        end
        ST_EMIT: begin
          if (outReady) begin
            matchValid <= 1'b0;
            if (matchCount != CNT_MAX) matchCount <= matchCount + 1'b1;
            k  <= '0;
            mm <= '0;
            if (!all || last_p) begin
              state <= ST_COMPLETE;
              DONE  <= 1'b1;
            end else begin
              state <= ST_COMPARE;
              p     <= p - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_pattern_scanner.sv
// Scoreboard bench for dna_pattern_scanner: a reference search queues
// the expected hits, the handshake monitor pops and compares them.
module tb_dna_pattern_scanner;

  localparam int B  = 8;
  localparam int PB = 2;
  localparam logic [31:0] TXT = 32'h1248_1248;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] bigSeq;
  logic [7:0]  smallSeq;
  logic [2:0]  startIndex;
  logic [1:0]  mismatchLimit;
  logic        findAll;
  logic        outReady;
  logic        matchValid;
  logic [2:0]  matchLoc;
  logic [1:0]  matchMm;
  logic        found;
  logic [2:0]  location;
  logic [3:0]  matchCount;
  logic        DONE;
  logic [4:0]  currState;

  int err_cnt = 0;
  int chk_cnt = 0;
  int q_loc[$];
  int q_mm[$];
  bit exp_found;
  int exp_loc;
  int exp_hits;
  int lat;

  always #5 CLK = ~CLK;

  dna_pattern_scanner #(
    .BASES     (B),
    .PAT_BASES (PB),
    .LOC_W     (3),
    .MM_W      (2)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .bigSeq        (bigSeq),
    .smallSeq      (smallSeq),
    .startIndex    (startIndex),
    .mismatchLimit (mismatchLimit),
    .findAll       (findAll),
    .outReady      (outReady),
    .matchValid    (matchValid),
    .matchLoc      (matchLoc),
    .matchMm       (matchMm),
    .found         (found),
    .location      (location),
    .matchCount    (matchCount),
    .DONE          (DONE),
    .currState     (currState)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic bit bm(input logic [3:0] a, input logic [3:0] b);
    return ((a & b) != 4'b0) || (a == b);
  endfunction

  // Whole-alignment reference: count all mismatches, keep if within limit.
  task automatic model(input logic [31:0] txt, input logic [7:0] pat,
                       input int si, input int lim, input bit fa);
    exp_found = 0;
    exp_loc   = 0;
    exp_hits  = 0;
    if (si < PB - 1 || si >= B) return;
    for (int p = si; p >= PB - 1; p--) begin
      int mm;
      mm = 0;
      for (int k = 0; k < PB; k++)
        if (!bm(txt[4*(p-k) +: 4], pat[4*(PB-1-k) +: 4])) mm++;
      if (mm <= lim) begin
        q_loc.push_back(p);
        q_mm.push_back(mm);
        if (!exp_found) exp_loc = p;
        exp_found = 1;
        exp_hits++;
        if (!fa) break;
      end
    end
  endtask

  task automatic kick(input logic [31:0] txt, input logic [7:0] pat,
                      input int si, input int lim, input bit fa);
    bigSeq        = txt;
    smallSeq      = pat;
    startIndex    = 3'(si);
    mismatchLimit = 2'(lim);
    findAll       = fa;
    START         = 1'b1;
    tick;
    START         = 1'b0;
  endtask

  task automatic run_scan(input logic [31:0] txt, input logic [7:0] pat,
                          input int si, input int lim, input bit fa,
                          input int stall);
    bit stalled;
    int cnt_exp;
    model(txt, pat, si, lim, fa);
    outReady = 1'b1;
    kick(txt, pat, si, lim, fa);
    lat = 1;
    stalled = 0;
    while (!DONE && lat < 300) begin
      if (matchValid) begin
        if (stall > 0 && !stalled) begin
          stalled  = 1;
          outReady = 1'b0;
          for (int i = 0; i < stall; i++) begin
            tick;
            lat++;
            check("stall_valid", 32'(matchValid), 1);
            check("stall_loc", 32'(matchLoc), q_loc[0]);
            check("stall_mm", 32'(matchMm), q_mm[0]);
            check("stall_count", 32'(matchCount), 0);
          end
          outReady = 1'b1;
        end
        check("hit_avail", 32'(q_loc.size() > 0), 1);
        if (q_loc.size() > 0) begin
          check("hit_loc", 32'(matchLoc), q_loc.pop_front());
          check("hit_mm", 32'(matchMm), q_mm.pop_front());
        end
      end
      tick;
      lat++;
    end
    cnt_exp = exp_hits > 15 ? 15 : exp_hits;
    check("done", 32'(DONE), 1);
    check("found", 32'(found), 32'(exp_found));
    if (exp_found) check("location", 32'(location), exp_loc);
    check("match_count", 32'(matchCount), cnt_exp);
    check("missing_hits", q_loc.size(), 0);
    check("state_complete", 32'(currState), 5'b10000);
    check("valid_low", 32'(matchValid), 0);
    q_loc.delete();
    q_mm.delete();
  endtask

  initial begin
    RST           = 1'b1;
    START         = 1'b0;
    bigSeq        = '0;
    smallSeq      = '0;
    startIndex    = '0;
    mismatchLimit = '0;
    findAll       = 1'b0;
    outReady      = 1'b1;
    tick;
    tick;
    check("rst_state", 32'(currState), 5'b00001);
    check("rst_valid", 32'(matchValid), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_count", 32'(matchCount), 0);
    RST = 1'b0;
    tick;

    // First hit only, then all hits, then all hits with a stalled consumer.
    run_scan(TXT, 8'h24, 7, 0, 1'b0, 0);
    run_scan(TXT, 8'h24, 7, 0, 1'b1, 0);
    run_scan(TXT, 8'h24, 7, 0, 1'b1, 5);
    run_scan(TXT, 8'h88, 7, 1, 1'b1, 0);
    run_scan(TXT, 8'h88, 7, 1, 1'b0, 0);
    run_scan(TXT, 8'hFF, 7, 0, 1'b1, 0);
    run_scan(TXT, 8'h81, 6, 3, 1'b1, 0);
    run_scan(TXT, 8'h18, 7, 0, 1'b1, 2);
    run_scan(TXT, 8'hFF, 0, 0, 1'b1, 0);
    check("done_latency", lat, 2);

    // Reset while a hit is waiting for the consumer.
    outReady = 1'b0;
    kick(TXT, 8'h24, 7, 0, 1'b1);
    lat = 0;
    while (!matchValid && lat < 50) begin
      tick;
      lat++;
    end
    check("pre_rst_valid", 32'(matchValid), 1);
    START = 1'b1;
    tick;
    START = 1'b0;
    check("start_ignored", 32'(currState), 5'b01000);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("mid_rst_state", 32'(currState), 5'b00001);
    check("mid_rst_valid", 32'(matchValid), 0);
    check("mid_rst_loc", 32'(matchLoc), 0);
    check("mid_rst_mm", 32'(matchMm), 0);
    check("mid_rst_found", 32'(found), 0);
    check("mid_rst_location", 32'(location), 0);
    check("mid_rst_count", 32'(matchCount), 0);
    check("mid_rst_done", 32'(DONE), 0);
    run_scan(TXT, 8'h24, 7, 0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
